// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - opcodes, state enum, control word and state decode for the multi-cycle MIPS control
package mips_mc_pkg;

  // Opcodes, using the same values as the single-cycle decoder
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // ALU B-input select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_RD    = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WR    = 4'd6,
    ST_EXEC_R    = 4'd7,
    ST_R_WB      = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_ADDI_EXEC = 4'd10,
    ST_ADDI_WB   = 4'd11,
    ST_JUMP      = 4'd12,
    ST_ILLEGAL   = 4'd13
  } mc_state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } mc_ctrl_t;

  // Pure Moore decode; FETCH and MEM_WR strobes are handshake-qualified by the caller
  function automatic mc_ctrl_t mc_ctrl_decode(input mc_state_t s);
    mc_ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.pc_write  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
      end
      ST_DECODE: c.alu_src_b = SRCB_IMM_SH;
      ST_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
      end
      ST_MEM_WR: begin
        c.mem_write  = 1'b1;
        c.i_or_d     = 1'b1;
        c.instr_done = 1'b1;
      end
      ST_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
        c.instr_done    = 1'b1;
      end
      ST_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      ST_ADDI_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      ST_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PCSRC_JUMP;
        c.instr_done = 1'b1;
      end
      ST_ILLEGAL: begin
        c.illegal_op = 1'b1;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_mc_control.sv
// rtl/mips_mc_control.sv - multi-cycle MIPS main control FSM
module mips_mc_control
  import mips_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  mc_state_t state_q, state_d;
  mc_ctrl_t  ctrl;

  // The zero flag is consumed outside, where it qualifies pc_write_cond
  logic unused_zero;
  assign unused_zero = zero;

  // State register; reset drops to IDLE at once so every output clears in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state sequencing; opcode is only looked at in DECODE and MEM_ADDR
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:      state_d = ST_FETCH;
      ST_FETCH:     state_d = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = ST_EXEC_R;
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI:      state_d = ST_ADDI_EXEC;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ST_ILLEGAL;
        endcase
      end
      ST_MEM_ADDR:  state_d = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:    state_d = mem_ready ? ST_MEM_WB : ST_MEM_RD;
      ST_MEM_WB:    state_d = ST_FETCH;
      ST_MEM_WR:    state_d = mem_ready ? ST_FETCH : ST_MEM_WR;
      ST_EXEC_R:    state_d = ST_R_WB;
      ST_R_WB:      state_d = ST_FETCH;
      ST_BRANCH:    state_d = ST_FETCH;
      ST_ADDI_EXEC: state_d = ST_ADDI_WB;
      ST_ADDI_WB:   state_d = ST_FETCH;
      ST_JUMP:      state_d = ST_FETCH;
      ST_ILLEGAL:   state_d = ST_FETCH;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output decode with the memory handshake gating the fetch strobes and store completion
  always_comb begin
    ctrl = mc_ctrl_decode(state_q);
    if (state_q == ST_FETCH) begin
      ctrl.pc_write = mem_ready;
      ctrl.ir_write = mem_ready;
    end
    if (state_q == ST_MEM_WR) begin
      ctrl.instr_done = mem_ready;
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign instr_done    = ctrl.instr_done;
  assign illegal_op    = ctrl.illegal_op;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// tb/tb_mips_mc_control.sv - directed self-checking bench for the multi-cycle MIPS control FSM
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       instr_done, illegal_op;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // Hand-assigned state numbers
  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MADDR = 3, S_MRD = 4, S_MWB = 5;
  localparam int S_MWR = 6, S_EXR = 7, S_RWB = 8, S_BR = 9, S_AEX = 10, S_AWB = 11;
  localparam int S_JMP = 12, S_ILL = 13;

  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
  //  reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal_op}
  logic [17:0] outs;
  assign outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                 reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal_op};

  mips_mc_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and land mid-cycle, away from the edge
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    #3;
    chk("reset_state", state_dbg, S_IDLE);
    chk("reset_outs", outs, 18'h0);

    // Release reset: IDLE for one cycle, then FETCH with mem_read
    tick; rst = 1'b0; #1;
    chk("rel_idle", state_dbg, S_IDLE);
    chk("rel_no_read", mem_read, 0);
    tick;
    chk("first_fetch", state_dbg, S_FETCH);
    // FETCH, ready: mem_read, pc_write, ir_write, alu_src_b=01
    chk("fetch_outs", outs, 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0);

    // LW with ready held: 5 cycles
    opcode = 6'h23;
    tick; chk("lw_c2", state_dbg, S_DECODE);
    chk("decode_outs", outs, 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0);
    tick; chk("lw_c3", state_dbg, S_MADDR);
    chk("maddr_outs", outs, 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0);
    tick; chk("lw_c4", state_dbg, S_MRD);
    chk("mrd_outs", outs, 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0);
    tick; chk("lw_c5", state_dbg, S_MWB);
    chk("mwb_outs", outs, 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0);
    tick; chk("lw_next", state_dbg, S_FETCH);

    // FETCH stall for two cycles
    mem_ready = 1'b0; #1;
    chk("fstall1_pcw", {pc_write, ir_write}, 2'b00);
    chk("fstall1_rd", mem_read, 1);
    tick;
    chk("fstall2_state", state_dbg, S_FETCH);
    chk("fstall2_pcw", {pc_write, ir_write}, 2'b00);
    tick;
    mem_ready = 1'b1; #1;
    chk("fstall_done_pcw", {pc_write, ir_write}, 2'b11);

    // SW with three wait cycles in MEM_WR
    opcode = 6'h2B;
    tick; chk("sw_dec", state_dbg, S_DECODE);
    tick; chk("sw_addr", state_dbg, S_MADDR);
    tick; mem_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("sw_wait_state", state_dbg, S_MWR);
      chk("sw_wait_wr", {mem_write, instr_done, reg_write}, 3'b100);
      tick;
    end
    mem_ready = 1'b1; #1;
    chk("sw_done", outs, 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0);
    tick; chk("sw_next", state_dbg, S_FETCH);
    chk("sw_next_wr", mem_write, 0);

    // BEQ: 3 cycles
    opcode = 6'h04; zero = 1'b1;
    tick; tick;
    chk("beq_state", state_dbg, S_BR);
    chk("beq_outs", outs, 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0);
    tick; chk("beq_next", state_dbg, S_FETCH);

    // J: 3 cycles
    opcode = 6'h02;
    tick; tick;
    chk("j_state", state_dbg, S_JMP);
    chk("j_outs", outs, 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0);
    tick; chk("j_next", state_dbg, S_FETCH);

    // R-type: opcode changes after DECODE are ignored
    opcode = 6'h00;
    tick; tick;
    chk("r_exec", state_dbg, S_EXR);
    chk("r_exec_outs", outs, 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0);
    opcode = 6'h23;
    tick; chk("r_wb", state_dbg, S_RWB);
    chk("r_wb_outs", outs, 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0);
    tick; chk("r_next", state_dbg, S_FETCH);

    // ADDI: 4 cycles
    opcode = 6'h08;
    tick; tick;
    chk("addi_exec", state_dbg, S_AEX);
    chk("addi_exec_outs", outs, 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0);
    tick; chk("addi_wb", state_dbg, S_AWB);
    chk("addi_wb_outs", outs, 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0);
    tick; chk("addi_next", state_dbg, S_FETCH);

    // Illegal opcode
    opcode = 6'h3F;
    tick; tick;
    chk("ill_state", state_dbg, S_ILL);
    chk("ill_outs", outs, 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_1_1);
    tick; chk("ill_next", state_dbg, S_FETCH);
    chk("ill_pulse_gone", illegal_op, 0);
    chk("ill_next_fetch", {mem_read, pc_write, ir_write}, 3'b111);

    // Reset asserted mid-store clears outputs immediately
    opcode = 6'h2B;
    tick; tick; tick;
    mem_ready = 1'b0; #1;
    chk("rst_pre_wr", mem_write, 1);
    rst = 1'b1; #1;
    chk("rst_async_state", state_dbg, S_IDLE);
    chk("rst_async_outs", outs, 18'h0);
    tick; mem_ready = 1'b1; rst = 1'b0; #1;
    chk("rst_rel_idle", state_dbg, S_IDLE);
    tick;
    chk("rst_rel_fetch", state_dbg, S_FETCH);
    chk("rst_rel_read", mem_read, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multi-cycle MIPS main control FSM.
- Sequences the shared datapath (one memory, one ALU, register file, PC, IR) through fetch, decode, execute, memory and writeback steps.
- Supports the same instruction subset as the single-cycle decoder: R-type, LW, SW, BEQ, ADDI, J.
- Memory accesses use a ready handshake, so a slow memory stretches a step.

Parameters:
- none; opcodes, encodings and state enum come from the shared package.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- opcode  in  6  IR[31:26]; valid from the DECODE state onward
- zero  in  1  ALU zero flag, used in BRANCH
- mem_ready  in  1  memory has completed the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified externally by zero
- i_or_d  out  1  0 = memory address from PC; 1 = memory address from ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  1  register write data from MDR
- reg_dst  out  1  1 = write rd; 0 = write rt
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC; 1 = register A
- alu_src_b  out  2  00 = B; 01 = constant 4; 10 = sign-extended immediate; 11 = sign-extended immediate << 2
- alu_op  out  2  00 = add; 01 = sub; 10 = decode funct
- pc_source  out  2  00 = ALU result; 01 = ALUOut; 10 = jump target
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal_op  out  1  one-cycle pulse for an unsupported opcode
- state_dbg  out  4  current state encoding

Behaviour:
- State register is async-reset to IDLE; next-state logic is combinational.
- Outputs are a Moore decode of the state. Exceptions: pc_write/ir_write in FETCH and instr_done in the memory states are additionally qualified by mem_ready.
- IDLE: all outputs 0. Always moves to FETCH. This covers reset and the first cycle after reset release.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - pc_write = ir_write = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target). Next state by opcode:
  - 0x00 -> EXEC_R
  - 0x23 / 0x2B -> MEM_ADDR
  - 0x04 -> BRANCH
  - 0x08 -> ADDI_EXEC
  - 0x02 -> JUMP
  - any other -> ILLEGAL
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD if opcode=0x23, otherwise MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Goes to FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Holds until mem_ready.
  - instr_done = mem_ready.
  - Goes to FETCH on mem_ready.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10. Goes to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Goes to FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Goes to FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Goes to FETCH.
- ILLEGAL: illegal_op=1, instr_done=1, no writes. Goes to FETCH; PC has already advanced past the instruction.
- Any output not listed for a state is 0.
- Latency with mem_ready held at 1:
  - LW: 5 cycles
  - SW, R-type, ADDI: 4 cycles
  - BEQ, J, illegal: 3 cycles
  - Each wait cycle adds one.
- mem_write and reg_write are never asserted together; pc_write and pc_write_cond are never asserted together.
- rst asserted mid-instruction: goes to IDLE immediately, all outputs 0 in the same cycle (asynchronous). No partial write completes after reset is seen.
- opcode is sampled only in DECODE and MEM_ADDR; changes in other states are ignored.
- Unreachable state encodings recover to IDLE.

Decomposition:
- Package mips_mc_pkg holds:
  - opcode localparams (shared with the single-cycle package values)
  - mc_state_t enum, 4-bit
  - mc_ctrl_t packed struct of the control outputs
  - encodings for alu_src_b, alu_op and pc_source
- One function, state-to-mc_ctrl_t, lives in the package; the module holds only the state register, next-state logic and mem_ready qualification.
- No sub-module.

Test Plan:
- Reset: rst pulse mid-MEM_WR with mem_write=1 -> all outputs 0 in the same cycle; after release, state sequence IDLE -> FETCH; first mem_read=1 one cycle after rst falls.
- LW (opcode 0x23), mem_ready=1 -> FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB; reg_write=1 and mem_to_reg=1 only in cycle 5; instr_done in cycle 5.
- SW (0x2B) with mem_ready low for 3 cycles in MEM_WR -> mem_write high for exactly 4 cycles; instr_done only on the cycle mem_ready=1.
- FETCH with mem_ready=0 for 2 cycles -> pc_write=ir_write=0 for those cycles, then both 1 for one cycle; DECODE follows.
- BEQ (0x04) then J (0x02) -> 3 cycles each; BEQ cycle 3: pc_write_cond=1, alu_op=01, pc_source=01; J cycle 3: pc_write=1, pc_source=10.
- Opcode 0x3F -> ILLEGAL on cycle 3 with illegal_op=1 for one cycle; reg_write and mem_write stay 0; next instruction fetches normally.
